hazard_forward_unit: RTL
========================

Name: hazard_forward_unit

Overview:
- Next-generation hazard controller for the 5-stage pipeline; supersedes the combinational forwarding unit.
- Generates the EX-stage ALU operand forwarding selects with a third source: a write-back bypass register that covers register files without write-through.
- Detects load-use hazards and stalls the ID stage.
- Tracks a multi-cycle multiply/divide unit with a busy counter and stalls dependent instructions.

Parameters:
- REG_ADDR_W, 5, register address width; address 0 is hardwired zero and is never forwarded.
- MD_LATENCY, 4, mult/div occupancy in cycles, counted from the accepting cycle; legal range 1..15.
- WB_BYPASS_EN, 1, 1 enables the write-back bypass source (select 2'b11); 0 never produces 2'b11.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- id_rs, id_rt  in  REG_ADDR_W  source registers of the instruction in ID
- id_uses_rs, id_uses_rt  in  1  ID instruction actually reads rs / rt
- id_md_start  in  1  ID instruction is mult/div
- id_reads_hilo  in  1  ID instruction is mfhi/mflo
- id_ex_mem_read  in  1  instruction in EX is a load
- id_ex_dest_reg  in  REG_ADDR_W  destination of the instruction in EX
- ex_rs, ex_rt  in  REG_ADDR_W  source registers of the instruction in EX
- ex_mem_reg_write, mem_wb_reg_write  in  1  write enables of the later stages
- ex_mem_dest_reg, mem_wb_dest_reg  in  REG_ADDR_W  destinations of the later stages
- alu_port1_mux_sel, alu_port2_mux_sel  out  2  00 regfile, 01 EX/MEM, 10 MEM/WB, 11 WB bypass
- stall_if_id  out  1  hold PC and IF/ID
- flush_id_ex  out  1  insert a bubble into ID/EX
- md_busy  out  1  mult/div unit occupied

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high. While reset is high, all outputs are 0 and the selects are 00. On the first edge with reset high, the bypass register and the counter clear.
- Forwarding, per port, combinational:
  - A stage hits when its write enable is 1, its dest != 0 and its dest == the source.
  - Priority: EX/MEM (01), then MEM/WB (10), then WB bypass (11, only if WB_BYPASS_EN and wb_valid), else 00.
  - The youngest producer always wins.
- WB bypass register: on every edge, wb_valid <= mem_wb_reg_write && mem_wb_dest_reg != 0, and wb_dest <= mem_wb_dest_reg. The data path holds the matching value.
- Load-use:
  - Condition: id_ex_mem_read, id_ex_dest_reg != 0, and a match with (id_rs && id_uses_rs) or (id_rt && id_uses_rt).
  - Response: stall_if_id = 1 and flush_id_ex = 1 for exactly that cycle. The bubble removes the condition, so the stall lasts one cycle.
- Mult/div FSM, states IDLE and BUSY, 4-bit counter:
  - IDLE: md_busy = 0. An accepted id_md_start (not stalled this cycle) with MD_LATENCY > 1 loads cnt = MD_LATENCY-1 and moves to BUSY. With MD_LATENCY = 1 it stays IDLE.
  - BUSY: md_busy = 1 and cnt decrements each edge. At cnt == 1 the next state is IDLE.
  - A busy stall is raised when BUSY and (id_md_start || id_reads_hilo). It asserts stall_if_id and flush_id_ex.
  - Dependents are released in the cycle after the FSM returns to IDLE.
- Simultaneous events:
  - The stall and flush outputs are the OR of the load-use and busy conditions.
  - id_md_start is not accepted while either stall is active.
  - A new start on the exact cycle BUSY ends is not accepted. It waits one cycle in IDLE.
- Reset mid-operation: the FSM returns to IDLE and the counter clears; the in-flight op is abandoned.
- The selects never depend on stall state. They depend only on the EX/MEM/WB fields and the bypass register.

Decomposition:
- Shared package hazard_pkg holds:
  - FWD_REGFILE, FWD_EXMEM, FWD_MEMWB, FWD_WBBYP (2-bit)
  - MD_IDLE, MD_BUSY
  - the default REG_ADDR_W
- One natural sub-module, fwd_select: a per-operand priority encoder, instantiated twice for rs and rt.

Test Plan:
1. ex_mem_reg_write = 1, ex_mem_dest_reg = 8, mem_wb_reg_write = 1, mem_wb_dest_reg = 8, ex_rs = 8 -> alu_port1_mux_sel = 01 (youngest wins). Then ex_mem_reg_write = 0 -> 10.
2. Dest = 0 in all stages with ex_rs = ex_rt = 0 and all write enables 1 -> both selects 00.
3. Cycle N: mem_wb_reg_write = 1, mem_wb_dest_reg = 5. Cycle N+1: no other producers, ex_rt = 5 -> alu_port2_mux_sel = 11. Repeat with WB_BYPASS_EN = 0 -> 00.
4. id_ex_mem_read = 1, id_ex_dest_reg = 3, id_rt = 3, id_uses_rt = 1 -> stall_if_id = flush_id_ex = 1 for one cycle. With id_uses_rt = 0 -> no stall.
5. MD_LATENCY = 4: id_md_start pulse at cycle 0 -> md_busy high cycles 1-3. An mfhi held in ID from cycle 1 stalls cycles 1-3 and proceeds at cycle 4. A second id_md_start at cycle 3 is not accepted until cycle 4.
6. Assert reset at cycle 2 of a BUSY period -> next cycle md_busy = 0, stall = 0, selects 00. A fresh start after reset runs the full 4-cycle count.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared encodings for the hazard/forwarding controller: operand source
// selects, mult/div tracker states and the default register address width.
package hazard_pkg;

    localparam int REG_ADDR_W_DEF = 5;

    // ALU operand source selects
    localparam logic [1:0] FWD_REGFILE = 2'b00;
    localparam logic [1:0] FWD_EXMEM   = 2'b01;
    localparam logic [1:0] FWD_MEMWB   = 2'b10;
    localparam logic [1:0] FWD_WBBYP   = 2'b11;

    // Mult/div occupancy tracker states
    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_e;

endpackage

// File: rtl/fwd_select.sv
// Per-operand forwarding priority encoder. The youngest in-flight producer
// of the source register wins; register 0 is never forwarded.
module fwd_select
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W   = REG_ADDR_W_DEF,
    parameter bit WB_BYPASS_EN = 1'b1
) (
    input  logic [REG_ADDR_W-1:0] src,
    input  logic                  ex_mem_we,
    input  logic [REG_ADDR_W-1:0] ex_mem_dest,
    input  logic                  mem_wb_we,
    input  logic [REG_ADDR_W-1:0] mem_wb_dest,
    input  logic                  wb_valid,
    input  logic [REG_ADDR_W-1:0] wb_dest,
    output logic [1:0]            sel
);

    localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;

    logic ex_mem_hit_s;
    logic mem_wb_hit_s;
    logic wb_hit_s;

    // Stage hit detection and priority selection, youngest producer first
    always_comb begin
        ex_mem_hit_s = ex_mem_we && (ex_mem_dest != ZERO_REG) && (ex_mem_dest == src);
        mem_wb_hit_s = mem_wb_we && (mem_wb_dest != ZERO_REG) && (mem_wb_dest == src);
        wb_hit_s     = WB_BYPASS_EN && wb_valid && (wb_dest != ZERO_REG) && (wb_dest == src);
        sel          = FWD_REGFILE;
        if (ex_mem_hit_s) begin
            sel = FWD_EXMEM;
        end else if (mem_wb_hit_s) begin
            sel = FWD_MEMWB;
        end else if (wb_hit_s) begin
            sel = FWD_WBBYP;
        end else begin
            sel = FWD_REGFILE;
        end
    end

endmodule

// File: rtl/hazard_forward_unit.sv
// Hazard controller for the 5-stage pipeline: EX operand forwarding with a
// write-back bypass source, load-use stall, and mult/div occupancy tracking.
module hazard_forward_unit
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W   = REG_ADDR_W_DEF,
    parameter int MD_LATENCY   = 4,
    parameter bit WB_BYPASS_EN = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_uses_rs,
    input  logic                  id_uses_rt,
    input  logic                  id_md_start,
    input  logic                  id_reads_hilo,
    input  logic                  id_ex_mem_read,
    input  logic [REG_ADDR_W-1:0] id_ex_dest_reg,
    input  logic [REG_ADDR_W-1:0] ex_rs,
    input  logic [REG_ADDR_W-1:0] ex_rt,
    input  logic                  ex_mem_reg_write,
    input  logic                  mem_wb_reg_write,
    input  logic [REG_ADDR_W-1:0] ex_mem_dest_reg,
    input  logic [REG_ADDR_W-1:0] mem_wb_dest_reg,
    output logic [1:0]            alu_port1_mux_sel,
    output logic [1:0]            alu_port2_mux_sel,
    output logic                  stall_if_id,
    output logic                  flush_id_ex,
    output logic                  md_busy
);

    localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;
    // Counter load: occupancy includes the accepting cycle
    localparam logic [3:0] MD_LOAD  = 4'(MD_LATENCY - 1);
    localparam bit         MD_MULTI = (MD_LATENCY > 1);

    md_state_e             state_r;
    md_state_e             state_nxt_s;
    logic [3:0]            cnt_r;
    logic [3:0]            cnt_nxt_s;
    logic                  wb_valid_r;
    logic [REG_ADDR_W-1:0] wb_dest_r;

    logic [1:0]            sel1_s;
    logic [1:0]            sel2_s;
    logic                  lu_stall_s;
    logic                  busy_stall_s;
    logic                  md_accept_s;

    fwd_select #(
        .REG_ADDR_W   (REG_ADDR_W),
        .WB_BYPASS_EN (WB_BYPASS_EN)
    ) u_fwd_rs (
        .src         (ex_rs),
        .ex_mem_we   (ex_mem_reg_write),
        .ex_mem_dest (ex_mem_dest_reg),
        .mem_wb_we   (mem_wb_reg_write),
        .mem_wb_dest (mem_wb_dest_reg),
        .wb_valid    (wb_valid_r),
        .wb_dest     (wb_dest_r),
        .sel         (sel1_s)
    );

    fwd_select #(
        .REG_ADDR_W   (REG_ADDR_W),
        .WB_BYPASS_EN (WB_BYPASS_EN)
    ) u_fwd_rt (
        .src         (ex_rt),
        .ex_mem_we   (ex_mem_reg_write),
        .ex_mem_dest (ex_mem_dest_reg),
        .mem_wb_we   (mem_wb_reg_write),
        .mem_wb_dest (mem_wb_dest_reg),
        .wb_valid    (wb_valid_r),
        .wb_dest     (wb_dest_r),
        .sel         (sel2_s)
    );

    // Write-back bypass tag: remembers what retired last cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            wb_valid_r <= 1'b0;
            wb_dest_r  <= ZERO_REG;
        end else begin
            wb_valid_r <= mem_wb_reg_write && (mem_wb_dest_reg != ZERO_REG);
            wb_dest_r  <= mem_wb_dest_reg;
        end
    end

    // Stall conditions and mult/div start acceptance
    always_comb begin
        lu_stall_s   = id_ex_mem_read && (id_ex_dest_reg != ZERO_REG) &&
                       (((id_ex_dest_reg == id_rs) && id_uses_rs) ||
                        ((id_ex_dest_reg == id_rt) && id_uses_rt));
        busy_stall_s = (state_r == MD_BUSY) && (id_md_start || id_reads_hilo);
        md_accept_s  = (state_r == MD_IDLE) && id_md_start && !lu_stall_s && !busy_stall_s;
    end

    // Mult/div tracker state and counter register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= MD_IDLE;
            cnt_r   <= 4'd0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Mult/div tracker next state; single-cycle units never enter BUSY
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        case (state_r)
            MD_IDLE: begin
                if (md_accept_s && MD_MULTI) begin
                    state_nxt_s = MD_BUSY;
                    cnt_nxt_s   = MD_LOAD;
                end else begin
                    state_nxt_s = MD_IDLE;
                    cnt_nxt_s   = 4'd0;
                end
            end
            MD_BUSY: begin
                // A zero count here is unreachable; treat it as done rather than wrap
                if (cnt_r <= 4'd1) begin
                    state_nxt_s = MD_IDLE;
                    cnt_nxt_s   = 4'd0;
                end else begin
                    state_nxt_s = MD_BUSY;
                    cnt_nxt_s   = cnt_r - 4'd1;
                end
            end
            default: begin
                state_nxt_s = MD_IDLE;
                cnt_nxt_s   = 4'd0;
            end
        endcase
    end

    // Output drive; everything is forced quiet while reset is held
    always_comb begin
        alu_port1_mux_sel = FWD_REGFILE;
        alu_port2_mux_sel = FWD_REGFILE;
        stall_if_id       = 1'b0;
        flush_id_ex       = 1'b0;
        md_busy           = 1'b0;
        if (reset) begin
            alu_port1_mux_sel = FWD_REGFILE;
            alu_port2_mux_sel = FWD_REGFILE;
            stall_if_id       = 1'b0;
            flush_id_ex       = 1'b0;
            md_busy           = 1'b0;
        end else begin
            alu_port1_mux_sel = sel1_s;
            alu_port2_mux_sel = sel2_s;
            stall_if_id       = lu_stall_s || busy_stall_s;
            flush_id_ex       = lu_stall_s || busy_stall_s;
            md_busy           = (state_r == MD_BUSY);
        end
    end

endmodule
